// File: rtl/tile_sprite_renderer_pkg.sv
// Shared definitions for the tile/sprite renderer: colours, animation
// state encoding and sprite frame numbers.
package tile_render_pkg;

    localparam logic [11:0] HP_RED     = 12'hB00;
    localparam logic [11:0] HP_BG      = 12'h333;
    localparam logic [11:0] SEL_BORDER = 12'h4AF;

    localparam int FRAME_W = 3;

    localparam logic [FRAME_W-1:0] FRAME_IDLE0     = 3'd0;
    localparam logic [FRAME_W-1:0] FRAME_IDLE1     = 3'd1;
    localparam logic [FRAME_W-1:0] FRAME_ATK_FIRST = 3'd2;
    localparam logic [FRAME_W-1:0] FRAME_ATK_LAST  = 3'd5;

    typedef enum logic {
        ANIM_IDLE   = 1'b0,
        ANIM_ATTACK = 1'b1
    } anim_state_t;

    // Brighten the green channel by one step without spilling into red.
    function automatic logic [11:0] green_inc(input logic [11:0] c);
        logic [11:0] r;
        r = c;
        if (c[7:4] != 4'hF)
            r[7:4] = c[7:4] + 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/tile_sprite_renderer_if.sv
// Read buses to the map, tile-texture and sprite ROMs (1-cycle latency).
interface tile_sprite_renderer_if #(
    parameter int NUM_SPRITES = 4
);
    logic [8:0]                map_addr;
    logic [3:0]                map_data;
    logic [13:0]               tex_addr;
    logic [11:0]               tex_data;
    logic [NUM_SPRITES*13-1:0] spr_addr;
    logic [NUM_SPRITES*12-1:0] spr_data;

    modport master (
        output map_addr, tex_addr, spr_addr,
        input  map_data, tex_data, spr_data
    );

    modport slave (
        input  map_addr, tex_addr, spr_addr,
        output map_data, tex_data, spr_data
    );
endinterface

// File: rtl/tile_sprite_renderer_anim.sv
// Per-sprite animation sequencer: idle frames 0/1, attack frames 2..5.
module sprite_anim_fsm
    import tile_render_pkg::*;
#(
    parameter int IDLE_DIV = 8,
    parameter int ATK_DIV  = 4
) (
    input  logic               clk_25MHz,
    input  logic               reset,
    input  logic               anim_tick,
    input  logic               attack_req,
    output logic [FRAME_W-1:0] frame,
    output logic               attack_busy
);
    localparam int MAX_DIV = (IDLE_DIV > ATK_DIV) ? IDLE_DIV : ATK_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV + 1);

    anim_state_t        state, state_n;
    logic [FRAME_W-1:0] frame_q, frame_n;
    logic [CNT_W-1:0]   tick_q, tick_n;

    // State, frame and tick counter registers.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state   <= ANIM_IDLE;
            frame_q <= FRAME_IDLE0;
            tick_q  <= '0;
        end else begin
            state   <= state_n;
            frame_q <= frame_n;
            tick_q  <= tick_n;
        end
    end

    // Next-state: attack entry is immediate, all frame steps wait for a tick.
    always_comb begin
        state_n = state;
        frame_n = frame_q;
        tick_n  = tick_q;
        case (state)
            ANIM_IDLE: begin
                if (attack_req) begin
                    state_n = ANIM_ATTACK;
                    frame_n = FRAME_ATK_FIRST;
                    tick_n  = '0;
                end else if (anim_tick) begin
                    if (tick_q == CNT_W'(IDLE_DIV - 1)) begin
                        tick_n  = '0;
                        frame_n = (frame_q == FRAME_IDLE0) ? FRAME_IDLE1 : FRAME_IDLE0;
                    end else begin
                        tick_n = tick_q + 1'b1;
                    end
                end
            end
            ANIM_ATTACK: begin
                if (anim_tick) begin
                    if (tick_q == CNT_W'(ATK_DIV - 1)) begin
                        tick_n = '0;
                        if (frame_q == FRAME_ATK_LAST) begin
                            state_n = ANIM_IDLE;
                            frame_n = FRAME_IDLE0;
                        end else begin
                            frame_n = frame_q + 1'b1;
                        end
                    end else begin
                        tick_n = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ANIM_IDLE;
                frame_n = FRAME_IDLE0;
                tick_n  = '0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        frame       = frame_q;
        attack_busy = (state == ANIM_ATTACK);
    end

endmodule

// File: rtl/tile_sprite_renderer.sv
// Tile-map renderer with animated sprite overlay, health bars and a
// selection cursor. Three-stage pipeline: map fetch, texel fetch, compose.
module tile_sprite_renderer
    import tile_render_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int TILE_BITS   = 5,
    parameter int MAP_W       = 20,
    parameter int MAP_H       = 15,
    parameter int HP_BITS     = 4,
    parameter int IDLE_DIV    = 8,
    parameter int ATK_DIV     = 4
) (
    input  logic                          clk_25MHz,
    input  logic                          reset,
    input  logic [9:0]                    h_cnt,
    input  logic [9:0]                    v_cnt,
    input  logic                          valid_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          anim_tick,
    input  logic [NUM_SPRITES*9-1:0]      sprite_pos,
    input  logic [NUM_SPRITES*HP_BITS-1:0] sprite_hp,
    input  logic [NUM_SPRITES-1:0]        attack_req,
    input  logic [8:0]                    selected_pos,
    tile_sprite_renderer_if.master        rom,
    output logic [11:0]                   pixel,
    output logic                          hsync,
    output logic                          vsync,
    output logic [NUM_SPRITES-1:0]        attack_busy
);
    localparam int TILE      = 1 << TILE_BITS;
    localparam int MAP_TILES = MAP_W * MAP_H;

    logic [FRAME_W-1:0] frame [NUM_SPRITES];

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_anim
        sprite_anim_fsm #(
            .IDLE_DIV (IDLE_DIV),
            .ATK_DIV  (ATK_DIV)
        ) u_anim (
            .clk_25MHz   (clk_25MHz),
            .reset       (reset),
            .anim_tick   (anim_tick),
            .attack_req  (attack_req[g]),
            .frame       (frame[g]),
            .attack_busy (attack_busy[g])
        );
    end

    // Frame-stable copies of the game state.
    logic [8:0]         pos_q [NUM_SPRITES];
    logic [HP_BITS-1:0] hp_q  [NUM_SPRITES];
    logic [8:0]         sel_q;

    // Latch positions/health/cursor only during the (delayed) vsync pulse.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                pos_q[i] <= 9'h1FF;
                hp_q[i]  <= '0;
            end
            sel_q <= 9'h1FF;
        end else if (!vsync) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                pos_q[i] <= sprite_pos[i*9 +: 9];
                hp_q[i]  <= sprite_hp[i*HP_BITS +: HP_BITS];
            end
            sel_q <= selected_pos;
        end
    end

    // Stage 0: tile coordinates and map address from the raw counters.
    logic [9:0] tile_x0, tile_y0, tile_idx0;
    logic       on_map0;

    // Tile lookup for the current counter position.
    always_comb begin
        tile_x0      = h_cnt >> TILE_BITS;
        tile_y0      = v_cnt >> TILE_BITS;
        tile_idx0    = tile_x0 + 10'(MAP_W) * tile_y0;
        on_map0      = (tile_x0 < 10'(MAP_W)) && (tile_y0 < 10'(MAP_H));
        rom.map_addr = tile_idx0[8:0];
    end

    // Stage 1 registers.
    logic [TILE_BITS-1:0] lx1, ly1;
    logic [9:0]           tile1;
    logic                 on_map1, valid1, hs1, vs1;

    // Capture in-tile coordinates alongside the map fetch.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            lx1     <= '0;
            ly1     <= '0;
            tile1   <= '0;
            on_map1 <= 1'b0;
            valid1  <= 1'b0;
            hs1     <= 1'b1;
            vs1     <= 1'b1;
        end else begin
            lx1     <= h_cnt[TILE_BITS-1:0];
            ly1     <= v_cnt[TILE_BITS-1:0];
            tile1   <= tile_idx0;
            on_map1 <= on_map0;
            valid1  <= valid_in;
            hs1     <= hsync_in;
            vs1     <= vsync_in;
        end
    end

    logic [NUM_SPRITES*13-1:0] spr_addr_c;

    // Texture and sprite addresses: {image, ly, lx}.
    always_comb begin
        rom.tex_addr = 14'(lx1) + 14'(14'(ly1) << TILE_BITS)
                     + 14'(14'(rom.map_data) << (2 * TILE_BITS));
        spr_addr_c = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++)
            spr_addr_c[i*13 +: 13] = 13'(lx1) + 13'(13'(ly1) << TILE_BITS)
                                   + 13'(13'(frame[i]) << (2 * TILE_BITS));
        rom.spr_addr = spr_addr_c;
    end

    // Stage 2 registers.
    logic [TILE_BITS-1:0]   lx2, ly2;
    logic [NUM_SPRITES-1:0] hit2;
    logic                   sel2, valid2, hs2, vs2;

    // Resolve which sprites and whether the cursor cover this tile.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            lx2    <= '0;
            ly2    <= '0;
            hit2   <= '0;
            sel2   <= 1'b0;
            valid2 <= 1'b0;
            hs2    <= 1'b1;
            vs2    <= 1'b1;
        end else begin
            lx2 <= lx1;
            ly2 <= ly1;
            for (int unsigned i = 0; i < NUM_SPRITES; i++)
                hit2[i] <= on_map1 && (tile1 == {1'b0, pos_q[i]})
                        && ({1'b0, pos_q[i]} < 10'(MAP_TILES)) && (hp_q[i] != '0);
            sel2   <= on_map1 && (tile1 == {1'b0, sel_q}) && ({1'b0, sel_q} < 10'(MAP_TILES));
            valid2 <= valid1;
            hs2    <= hs1;
            vs2    <= vs1;
        end
    end

    logic [TILE_BITS-1:0] bar_len [NUM_SPRITES];
    logic [11:0]          color;
    logic                 border;

    // Compose: tile, then sprites (lowest index on top), bars, cursor.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++)
            bar_len[i] = TILE_BITS'(hp_q[i]) << (TILE_BITS - HP_BITS);
        border = (lx2 < TILE_BITS'(2)) || (lx2 > TILE_BITS'(TILE - 3))
              || (ly2 < TILE_BITS'(2)) || (ly2 > TILE_BITS'(TILE - 3));
        color = rom.tex_data;
        // Walk from the highest index down so lower indices overwrite.
        for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
            if (hit2[NUM_SPRITES-1-k] && (rom.spr_data[(NUM_SPRITES-1-k)*12 +: 12] != '0))
                color = rom.spr_data[(NUM_SPRITES-1-k)*12 +: 12];
        end
        for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
            if (hit2[NUM_SPRITES-1-k] && (ly2 < TILE_BITS'(2)))
                color = (lx2 < bar_len[NUM_SPRITES-1-k]) ? HP_RED : HP_BG;
        end
        if (sel2)
            color = border ? SEL_BORDER : green_inc(color);
    end

    // Stage 3: registered pixel and syncs, blanked outside the active area.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            pixel <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            pixel <= valid2 ? color : 12'h000;
            hsync <= hs2;
            vsync <= vs2;
        end
    end

endmodule

// File: tb/tb_tile_sprite_renderer.sv
// Directed bench for tile_sprite_renderer with behavioural ROM models.
module tb_tile_sprite_renderer;
    logic        clk_25MHz = 1'b0;
    logic        reset;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid_in, hsync_in, vsync_in, anim_tick;
    logic [35:0] sprite_pos;
    logic [15:0] sprite_hp;
    logic [3:0]  attack_req;
    logic [8:0]  selected_pos;
    logic [11:0] pixel;
    logic        hsync, vsync;
    logic [3:0]  attack_busy;
    logic [11:0] spr_tex [4];

    int vectors    = 0;
    int miscompares = 0;

    always #20 clk_25MHz = ~clk_25MHz;

    tile_sprite_renderer_if #(.NUM_SPRITES(4)) rom_bus ();

    tile_sprite_renderer #(
        .NUM_SPRITES (4),
        .TILE_BITS   (5),
        .MAP_W       (20),
        .MAP_H       (15),
        .HP_BITS     (4),
        .IDLE_DIV    (8),
        .ATK_DIV     (4)
    ) dut (
        .clk_25MHz    (clk_25MHz),
        .reset        (reset),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .valid_in     (valid_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .anim_tick    (anim_tick),
        .sprite_pos   (sprite_pos),
        .sprite_hp    (sprite_hp),
        .attack_req   (attack_req),
        .selected_pos (selected_pos),
        .rom          (rom_bus),
        .pixel        (pixel),
        .hsync        (hsync),
        .vsync        (vsync),
        .attack_busy  (attack_busy)
    );

    // Map: tile 0 -> image 1, tile 125 -> image 2, all else image 0.
    function automatic logic [3:0] map_img(input logic [8:0] a);
        if (a == 9'd0)   return 4'd1;
        if (a == 9'd125) return 4'd2;
        return 4'd0;
    endfunction

    function automatic logic [11:0] tex_img(input logic [3:0] img);
        case (img)
            4'd0:    return 12'h123;
            4'd1:    return 12'h0F5;
            4'd2:    return 12'h456;
            default: return 12'h000;
        endcase
    endfunction

    always @(posedge clk_25MHz) begin
        rom_bus.map_data <= map_img(rom_bus.map_addr);
        rom_bus.tex_data <= tex_img(rom_bus.tex_addr[13:10]);
        for (int i = 0; i < 4; i++)
            rom_bus.spr_data[i*12 +: 12] <= spr_tex[i];
    end

    task automatic step();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_sprite(input int i, input logic [8:0] pos, input logic [3:0] hp,
                              input logic [11:0] tex);
        sprite_pos[i*9 +: 9] = pos;
        sprite_hp[i*4 +: 4]  = hp;
        spr_tex[i]           = tex;
    endtask

    // Pulse vsync so the renderer picks up the new game state.
    task automatic load_frame();
        vsync_in = 1'b0;
        repeat (5) step();
        vsync_in = 1'b1;
        repeat (4) step();
    endtask

    task automatic px(input string tag, input int h, input int v, input logic [11:0] exp);
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        valid_in = 1'b1;
        repeat (3) step();
        check(tag, 32'(pixel), 32'(exp));
    endtask

    task automatic tick();
        anim_tick = 1'b1;
        step();
        anim_tick = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        h_cnt        = '0;
        v_cnt        = '0;
        valid_in     = 1'b0;
        hsync_in     = 1'b1;
        vsync_in     = 1'b1;
        anim_tick    = 1'b0;
        attack_req   = '0;
        selected_pos = 9'h1FF;
        for (int i = 0; i < 4; i++) set_sprite(i, 9'h1FF, 4'd0, 12'h000);
        repeat (3) step();

        check("rst_pixel", 32'(pixel), 32'h000);
        check("rst_hsync", 32'(hsync), 32'h1);
        check("rst_vsync", 32'(vsync), 32'h1);
        check("rst_busy", 32'(attack_busy), 32'h0);
        check("rst_frame0", 32'(rom_bus.spr_addr[12:10]), 32'h0);
        reset = 1'b0;
        step();

        // Single sprite over tile 125 (cols 160..191, rows 192..223).
        set_sprite(0, 9'd125, 4'd15, 12'h0F0);
        load_frame();
        px("spr_body_tl", 160, 194, 12'h0F0);
        px("spr_body_br", 191, 223, 12'h0F0);
        px("spr_right_nb", 192, 200, 12'h123);
        px("spr_left_nb", 159, 200, 12'h123);
        px("spr_bar_red_hp15", 189, 192, 12'hB00);
        px("spr_bar_bg_hp15", 190, 193, 12'h333);

        // Latency: a new position shows up on the third edge, not before.
        px("lat_prev", 100, 200, 12'h123);
        h_cnt = 10'd170;
        step();
        check("lat_edge1", 32'(pixel), 32'h123);
        step();
        check("lat_edge2", 32'(pixel), 32'h123);
        step();
        check("lat_edge3", 32'(pixel), 32'h0F0);

        // Blanking.
        valid_in = 1'b0;
        repeat (3) step();
        check("blank_valid_low", 32'(pixel), 32'h000);

        // Health 5 -> bar length 10.
        set_sprite(0, 9'd125, 4'd5, 12'h0F0);
        load_frame();
        px("hp5_bar_lx9", 169, 192, 12'hB00);
        px("hp5_bar_lx10", 170, 192, 12'h333);
        px("hp5_bar_lx31_row1", 191, 193, 12'h333);
        px("hp5_row2_body", 170, 194, 12'h0F0);

        // Transparent sprite texel reveals the tile.
        set_sprite(0, 9'd125, 4'd5, 12'h000);
        load_frame();
        px("spr_transparent", 170, 200, 12'h456);

        // Two sprites on tile 167: lowest index wins; hp 0 hides sprite 0.
        set_sprite(0, 9'd167, 4'd15, 12'h111);
        set_sprite(1, 9'd167, 4'd15, 12'h222);
        load_frame();
        px("overlap_s0_wins", 230, 270, 12'h111);
        set_sprite(0, 9'd167, 4'd0, 12'h111);
        load_frame();
        px("overlap_hp0_s1", 230, 270, 12'h222);

        // Selection cursor on tile 0 (green already saturated) and tile 1.
        set_sprite(0, 9'h1FF, 4'd0, 12'h000);
        set_sprite(1, 9'h1FF, 4'd0, 12'h000);
        selected_pos = 9'd0;
        load_frame();
        px("sel_border_lx0", 0, 5, 12'h4AF);
        px("sel_border_lx31", 31, 10, 12'h4AF);
        px("sel_border_ly30", 10, 30, 12'h4AF);
        px("sel_interior_sat", 10, 10, 12'h0F5);
        px("sel_interior_lx2", 2, 2, 12'h0F5);
        px("unselected_tile1", 40, 10, 12'h123);
        selected_pos = 9'd1;
        load_frame();
        px("sel_interior_inc", 40, 10, 12'h133);
        px("sel_border_lx1", 33, 10, 12'h4AF);
        valid_in = 1'b0;

        // Attack sequence on sprite 0, with a second request mid-attack.
        check("pre_atk_frame", 32'(rom_bus.spr_addr[12:10]), 32'h0);
        attack_req = 4'b0001;
        step();
        attack_req = 4'b0000;
        check("atk_enter_busy", 32'(attack_busy), 32'h1);
        check("atk_enter_frame", 32'(rom_bus.spr_addr[12:10]), 32'h2);
        for (int t = 1; t <= 20; t++) begin
            if (t == 6) attack_req = 4'b0001;
            tick();
            attack_req = 4'b0000;
            step();
            check($sformatf("atk_frame_t%0d", t), 32'(rom_bus.spr_addr[12:10]),
                  (t < 16) ? 32'(2 + t / 4) : 32'h0);
            check($sformatf("atk_busy_t%0d", t), 32'(attack_busy[0]), (t < 16) ? 32'h1 : 32'h0);
        end
        // Four idle ticks already counted; toggle to frame 1 after four more.
        repeat (3) begin
            tick();
            step();
        end
        check("idle_frame_hold", 32'(rom_bus.spr_addr[12:10]), 32'h0);
        tick();
        check("idle_frame_toggle", 32'(rom_bus.spr_addr[12:10]), 32'h1);

        // Reset during attack frame 3 aborts cleanly.
        attack_req = 4'b0001;
        step();
        attack_req = 4'b0000;
        repeat (5) tick();
        check("abort_pre_frame3", 32'(rom_bus.spr_addr[12:10]), 32'h3);
        px("abort_pre_pixel", 100, 200, 12'h123);
        reset = 1'b1;
        step();
        check("abort_busy", 32'(attack_busy), 32'h0);
        check("abort_frame0", 32'(rom_bus.spr_addr[12:10]), 32'h0);
        check("abort_pixel", 32'(pixel), 32'h000);
        reset = 1'b0;
        repeat (2) step();
        check("abort_after_frame0", 32'(rom_bus.spr_addr[12:10]), 32'h0);
        check("abort_after_busy", 32'(attack_busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
